// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache controller FSM and its wait timer.
package cache_ctrl_pkg;

    // Controller states. IDLE is the reset state.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        WRITE_BACK = 3'd2,
        ALLOCATE   = 3'd3,
        DONE       = 3'd4
    } ctrl_state_e;

    // Encoding of the CPU request type bit.
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on main memory. The counter is cleared on entry
// to a wait state and stops at MAX, where it flags expiry.
module mem_wait_timer #(
    parameter int MAX = 255,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, and the count saturates at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != W'(MAX)))
            cnt_d = cnt_q + W'(1);
    end

    // Counter register, forced to zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == W'(MAX));

endmodule

// File: rtl/cache_controller.sv
// Blocking cache controller: hit/miss compare, dirty write-back, line
// allocate, and a bounded wait on main memory with a timeout error.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req_valid,
    input  logic cpu_req_type,
    output logic cpu_ready,
    output logic cpu_done,
    output logic error,
    input  logic hit,
    input  logic dirty_bit,
    input  logic mem_ack,
    output logic req_type,
    output logic read_en_cache,
    output logic write_en_cache,
    output logic read_en_mem,
    output logic write_en_mem
);

    ctrl_state_e state_q, state_d;
    logic        req_type_q, req_type_d;
    logic        err_q, err_d;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_expired;

    mem_wait_timer #(
        .MAX (MEM_TIMEOUT),
        .W   (CNT_WIDTH)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Only cycles spent waiting without an acknowledge advance the timer.
    assign tmr_en = ((state_q == WRITE_BACK) || (state_q == ALLOCATE)) && !mem_ack;

    // Next-state logic; an acknowledge always takes priority over expiry.
    always_comb begin
        state_d    = state_q;
        req_type_d = req_type_q;
        err_d      = err_q;
        tmr_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (cpu_req_valid) begin
                    req_type_d = cpu_req_type;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = DONE;
                end else if (dirty_bit) begin
                    state_d = WRITE_BACK;
                    tmr_clr = 1'b1;
                end else begin
                    state_d = ALLOCATE;
                    tmr_clr = 1'b1;
                end
            end
            WRITE_BACK: begin
                if (mem_ack) begin
                    state_d = ALLOCATE;
                    tmr_clr = 1'b1;
                end else if (tmr_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    state_d = COMPARE;
                end else if (tmr_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // FSM register: state, latched request type and pending-timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_type_q <= REQ_READ;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_type_q <= req_type_d;
            err_q      <= err_d;
        end
    end

    // Output decode from the state register, latched type and hit only.
    always_comb begin
        cpu_ready      = 1'b0;
        cpu_done       = 1'b0;
        error          = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        case (state_q)
            IDLE:    cpu_ready = 1'b1;
            COMPARE: begin
                read_en_cache  = hit && (req_type_q == REQ_READ);
                write_en_cache = hit && (req_type_q == REQ_WRITE);
            end
            WRITE_BACK: begin
                read_en_cache = 1'b1;
                write_en_mem  = 1'b1;
            end
            ALLOCATE: begin
                read_en_mem    = 1'b1;
                write_en_cache = 1'b1;
            end
            DONE: begin
                cpu_done = 1'b1;
                error    = err_q;
            end
            default: cpu_ready = 1'b0;
        endcase
    end

    assign req_type = req_type_q;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench: each transaction is expanded into an expected per-cycle
// trace of outputs (with the inputs to apply) and replayed against the DUT.
module tb_cache_controller;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_req_valid, cpu_req_type, hit, dirty_bit, mem_ack;
    logic cpu_ready, cpu_done, error, req_type;
    logic read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    cache_controller #(.MEM_TIMEOUT(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_type   (cpu_req_type),
        .cpu_ready      (cpu_ready),
        .cpu_done       (cpu_done),
        .error          (error),
        .hit            (hit),
        .dirty_bit      (dirty_bit),
        .mem_ack        (mem_ack),
        .req_type       (req_type),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem)
    );

    always #5 clk = ~clk;

    assign obs = {cpu_ready, cpu_done, error, req_type,
                  read_en_cache, write_en_cache, read_en_mem, write_en_mem};

    typedef struct {
        logic       v, t, h, d, a;
        logic [7:0] e;
        string      tag;
    } cyc_t;

    cyc_t q[$];
    logic last_t;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ov(input logic rdy, done, err, t, rc, wc, rm, wm);
        return {rdy, done, err, t, rc, wc, rm, wm};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic v, t, h, d, a, input logic [7:0] e, input string tag);
        cyc_t c;
        c.v = v; c.t = t; c.h = h; c.d = d; c.a = a; c.e = e; c.tag = tag;
        q.push_back(c);
    endtask

    // A wait phase lasts until the ack (after dly idle cycles) or T+1 cycles
    // with no ack; returns 1 when it times out.
    task automatic wait_phase(input int dly, input logic is_wb, input logic t, output logic to);
        int n;
        n  = (dly > T) ? T + 1 : dly + 1;
        to = (dly > T);
        for (int i = 0; i < n; i++)
            push(rb(), rb(), rb(), rb(), (i == dly),
                 is_wb ? ov(0,0,0,t,1,0,0,1) : ov(0,0,0,t,0,1,1,0),
                 is_wb ? "wb" : "alloc");
    endtask

    task automatic gen_txn(input logic t, h1, d, input int wbd, ald, gap);
        logic to;
        for (int i = 0; i < gap; i++)
            push(0, rb(), rb(), rb(), rb(), ov(1,0,0,last_t,0,0,0,0), "idle");
        push(1, t, rb(), rb(), rb(), ov(1,0,0,last_t,0,0,0,0), "accept");
        last_t = t;
        push(rb(), rb(), h1, d, rb(), ov(0,0,0,t,h1 & ~t,h1 & t,0,0), "compare");
        if (h1) begin
            push(rb(), rb(), rb(), rb(), rb(), ov(0,1,0,t,0,0,0,0), "done");
        end else begin
            to = 1'b0;
            if (d) wait_phase(wbd, 1'b1, t, to);
            if (!to) wait_phase(ald, 1'b0, t, to);
            if (!to)
                push(rb(), rb(), 1'b1, rb(), rb(), ov(0,0,0,t,~t,t,0,0), "retry");
            push(rb(), rb(), rb(), rb(), rb(), ov(0,1,to,t,0,0,0,0), to ? "done_err" : "done");
        end
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            cpu_req_valid = c.v;
            cpu_req_type  = c.t;
            hit           = c.h;
            dirty_bit     = c.d;
            mem_ack       = c.a;
            #1 chk(c.tag, obs, c.e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_type = 1'b0;
        hit = 1'b0; dirty_bit = 1'b0; mem_ack = 1'b0;
        last_t = 1'b0;
        #12 chk("reset", obs, ov(1,0,0,0,0,0,0,0));
        @(negedge clk) rst_n = 1'b1;

        // directed: read hit, clean read miss, dirty write miss, timeouts, collision
        gen_txn(0, 1, 0, 0, 0, 1);
        gen_txn(0, 0, 0, 0, 3, 1);
        gen_txn(1, 0, 1, 2, 2, 0);
        gen_txn(0, 0, 0, 0, 9, 1);
        gen_txn(1, 0, 1, 7, 0, 0);
        gen_txn(0, 0, 0, 0, T, 2);
        gen_txn(1, 0, 1, T, T, 0);
        run_q();

        // reset while in ALLOCATE: enables drop at once, no done afterwards
        gen_txn(1, 0, 0, 0, 20, 0);
        while (q.size() > 4) void'(q.pop_back());
        run_q();
        @(negedge clk) #2 rst_n = 1'b0;
        #1 chk("rst_mid", obs, ov(1,0,0,0,0,0,0,0));
        @(negedge clk) chk("rst_hold", obs, ov(1,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        last_t = 1'b0;
        for (int i = 0; i < 3; i++)
            push(0, rb(), rb(), rb(), rb(), ov(1,0,0,0,0,0,0,0), "post_rst");
        run_q();

        // random traffic
        for (int n = 0; n < 200; n++) begin
            gen_txn(rb(), rb(), rb(), $urandom_range(0, T + 2),
                    $urandom_range(0, T + 2), $urandom_range(0, 2));
            run_q();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL expose parameter MEM_TIMEOUT, default 255, meaning the maximum number of wait cycles for mem_ack in WRITE_BACK or ALLOCATE before the request is aborted.
REQ-002 The block SHALL expose parameter CNT_WIDTH, default $clog2(MEM_TIMEOUT+1), meaning the width of the wait counter.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port cpu_req_valid, input, 1, meaning the CPU request is present.
REQ-006 The block SHALL have port cpu_req_type, input, 1, meaning the request type: 0 is read, 1 is write.
REQ-007 The block SHALL have port cpu_ready, output, 1, meaning the controller can accept a request.
REQ-008 The block SHALL have port cpu_done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port error, output, 1, a one-cycle timeout pulse that coincides with cpu_done.
REQ-010 The block SHALL have port hit, input, 1, the cache hit flag.
REQ-011 The block SHALL have port dirty_bit, input, 1, meaning the replacement victim is dirty.
REQ-012 The block SHALL have port mem_ack, input, 1, meaning main memory completed the current transfer.
REQ-013 The block SHALL have port req_type, output, 1, the latched request type driven to the cache.
REQ-014 The block SHALL have ports read_en_cache and write_en_cache, outputs, 1 each, the cache array enables.
REQ-015 The block SHALL have ports read_en_mem and write_en_mem, outputs, 1 each, the main memory enables.

Function
REQ-016 The block SHALL implement the FSM states IDLE, COMPARE, WRITE_BACK, ALLOCATE and DONE.
REQ-017 All outputs SHALL be decoded from the state register, the latched type and hit only, with no path from cpu_req_valid to any output.
REQ-018 In IDLE, cpu_ready SHALL be 1 and all other outputs SHALL be 0.
REQ-019 In IDLE, when cpu_req_valid is 1, the FSM SHALL latch cpu_req_type into req_type and move to COMPARE on the same edge.
REQ-020 In COMPARE with hit=1, the block SHALL assert read_en_cache when req_type=0, or write_en_cache when req_type=1, for exactly that cycle, and then go to DONE.
REQ-021 In COMPARE with hit=0 and dirty_bit=1, the FSM SHALL go to WRITE_BACK.
REQ-022 In COMPARE with hit=0 and dirty_bit=0, the FSM SHALL go to ALLOCATE.
REQ-023 In WRITE_BACK, read_en_cache and write_en_mem SHALL be held at 1, and on mem_ack=1 the FSM SHALL go to ALLOCATE.
REQ-024 In ALLOCATE, read_en_mem and write_en_cache SHALL be held at 1, and on mem_ack=1 the FSM SHALL go to COMPARE to retry the access.
REQ-025 In DONE, cpu_done SHALL be 1 for exactly one cycle, cpu_ready SHALL be 0, and the FSM SHALL then go to IDLE.
REQ-026 The latency of a hit SHALL be: accept edge, one COMPARE cycle, then cpu_done in the next cycle.
REQ-027 A miss SHALL add the WRITE_BACK and/or ALLOCATE wait cycles plus one COMPARE cycle to the hit latency.
REQ-028 The wait counter SHALL clear on entry to WRITE_BACK or ALLOCATE and increment every cycle spent there without mem_ack, saturating at MEM_TIMEOUT.
REQ-029 When the counter reaches MEM_TIMEOUT with mem_ack=0, the FSM SHALL go to DONE with error=1 asserted in the DONE cycle, and the cache SHALL not be retried.
REQ-030 If mem_ack=1 in the same cycle the counter reaches MEM_TIMEOUT, the acknowledge SHALL take priority and no error SHALL be raised.
REQ-031 A cpu_req_valid asserted while cpu_ready=0 SHALL be ignored and SHALL not be queued.
REQ-032 mem_ack outside WRITE_BACK and ALLOCATE SHALL be ignored.
REQ-033 The FSM SHALL never assert read_en_mem and write_en_mem in the same cycle.

Reset
REQ-034 While rst_n=0, the block SHALL force state to IDLE, the counter to 0, and req_type to 0 asynchronously.
REQ-035 During reset, cpu_ready SHALL read 1 and every other output SHALL read 0.
REQ-036 A reset asserted mid-transaction SHALL abandon the transaction without a cpu_done or error pulse.

Structure
REQ-037 Package cache_ctrl_pkg SHALL hold the ctrl_state_e enum and the localparams REQ_READ=0 and REQ_WRITE=1.
REQ-038 The wait counter SHALL be one sub-module, mem_wait_timer, with inputs clr and en and output expired.

Verification
REQ-039 Read hit: request with type 0 and hit=1 -> read_en_cache high for 1 cycle, cpu_done on cycle 2, no memory enables.
REQ-040 Clean read miss: hit=0, dirty_bit=0, mem_ack after 3 cycles, hit=1 on retry -> read_en_mem and write_en_cache high for 4 cycles, then COMPARE, then cpu_done.
REQ-041 Dirty write miss: hit=0, dirty_bit=1, mem_ack after 2 cycles in WRITE_BACK and after 2 cycles in ALLOCATE -> write_en_mem high, then read_en_mem high, then write_en_cache in COMPARE, then cpu_done.
REQ-042 Timeout: MEM_TIMEOUT=4 with mem_ack=0 -> error and cpu_done both high exactly once, then cpu_ready=1.
REQ-043 Ack/timeout collision: mem_ack=1 on the cycle the counter reaches 4 -> no error and the FSM proceeds normally.
REQ-044 Reset in ALLOCATE: drive rst_n=0 -> all enables drop to 0 immediately, no cpu_done, and the FSM is in IDLE after release.
